// File: rtl/gol_pkg.sv
// gol_pkg: shared definitions for the Game-of-Life generation scheduler.
//  - FSM state encodings (legacy-compatible localparam constants)
//  - neighbour slot indices NB_SELF..NB_SE (status vector bit positions)
//  - dx/dy offset tables for each slot
//  - life_rule: next state of a cell from its 9-bit status vector
package gol_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_FINISH  = 3'd4;

  // Status vector bit positions; also the fetch slot order.
  localparam logic [3:0] NB_SELF = 4'd0;
  localparam logic [3:0] NB_NW   = 4'd1;
  localparam logic [3:0] NB_N    = 4'd2;
  localparam logic [3:0] NB_NE   = 4'd3;
  localparam logic [3:0] NB_W    = 4'd4;
  localparam logic [3:0] NB_E    = 4'd5;
  localparam logic [3:0] NB_SW   = 4'd6;
  localparam logic [3:0] NB_S    = 4'd7;
  localparam logic [3:0] NB_SE   = 4'd8;

  function automatic int nb_dx(input logic [3:0] k);
    case (k)
      NB_NW, NB_W, NB_SW: nb_dx = -1;
      NB_NE, NB_E, NB_SE: nb_dx = 1;
      default:            nb_dx = 0;
    endcase
  endfunction

  function automatic int nb_dy(input logic [3:0] k);
    case (k)
      NB_NW, NB_N, NB_NE: nb_dy = -1;
      NB_SW, NB_S, NB_SE: nb_dy = 1;
      default:            nb_dy = 0;
    endcase
  endfunction

  // Birth on exactly 3 live neighbours, survival on 2 or 3.
  function automatic logic life_rule(input logic [8:0] status);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 1; i < 9; i++) begin
      n = n + 4'(status[i]);
    end
    return (~status[NB_SELF] & (n == 4'd3)) |
           (status[NB_SELF] & ((n == 4'd2) | (n == 4'd3)));
  endfunction

endpackage

// File: rtl/gol_nbr_addr.sv
// gol_nbr_addr: combinational neighbour address generator.
//  Maps (x, y, slot k, bank) to the RAM address of neighbour k and flags whether
//  that neighbour lies inside the grid.
//  Build option TORUS_WRAP_EN: out-of-grid coordinates wrap modulo WIDTH/HEIGHT
//  and in_grid is always 1. Without it, out-of-grid neighbours report in_grid=0.
// Ports:
//  x, y     in   current cell coordinates
//  k        in   neighbour slot (NB_SELF..NB_SE)
//  bank     in   bank select placed in the address MSB
//  addr     out  {bank, ny*WIDTH+nx}
//  in_grid  out  neighbour exists (always 1 with wrap)
module gol_nbr_addr
  import gol_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT) + 1,
  parameter int X_W    = $clog2(WIDTH),
  parameter int Y_W    = $clog2(HEIGHT)
) (
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [3:0]        k,
  input  logic              bank,
  output logic [ADDR_W-1:0] addr,
  output logic              in_grid
);

  localparam int IDX_W = ADDR_W - 1;

  int nx;
  int ny;

  always_comb begin
    nx = int'(x) + nb_dx(k);
    ny = int'(y) + nb_dy(k);
`ifdef TORUS_WRAP_EN
    in_grid = 1'b1;
    if (nx < 0) begin
      nx = nx + WIDTH;
    end else if (nx >= WIDTH) begin
      nx = nx - WIDTH;
    end
    if (ny < 0) begin
      ny = ny + HEIGHT;
    end else if (ny >= HEIGHT) begin
      ny = ny - HEIGHT;
    end
`else
    in_grid = (nx >= 0) && (nx < WIDTH) && (ny >= 0) && (ny < HEIGHT);
    if (!in_grid) begin
      nx = 0;
      ny = 0;
    end
`endif
    addr = {bank, IDX_W'(ny * WIDTH + nx)};
  end

endmodule

// File: rtl/generation_scheduler.sv
// generation_scheduler: sequences one Game-of-Life generation over a WIDTH x HEIGHT
// grid stored in a ping-pong RAM. Each cell takes 11 cycles: 9 fetch slots (self +
// 8 neighbours), one capture cycle for the last read, one write cycle. Reads come
// from cur_bank, writes go to ~cur_bank; cur_bank flips when the generation ends.
// Build option TORUS_WRAP_EN: neighbour coordinates wrap around the grid edges;
// otherwise out-of-grid neighbours are dead and their slot issues no read.
// Ports:
//  clk, rst_n        clock, asynchronous active-low reset
//  start             request one generation (sampled only in IDLE)
//  busy, done        generation in progress / one-cycle completion pulse
//  cur_bank          bank holding the displayed generation
//  rd_en, rd_addr    RAM read port; rd_data valid one cycle after rd_en
//  wr_en, wr_addr,
//  wr_data           RAM write port
//  live_count        live cells in the last completed generation
module generation_scheduler
  import gol_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              cur_bank,
  output logic                              rd_en,
  output logic [ADDR_W-1:0]                 rd_addr,
  input  logic                              rd_data,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic                              wr_data,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] live_count
);

  localparam int CNT_W = $clog2(WIDTH * HEIGHT + 1);
  localparam int IDX_W = ADDR_W - 1;
  localparam int X_W   = $clog2(WIDTH);
  localparam int Y_W   = $clog2(HEIGHT);

  logic [2:0]       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [3:0]       k_q, k_d;
  logic [8:0]       status_q, status_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bank_q, bank_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] live_q, live_d;

  // Read-return pipeline: which slot the data arriving this cycle belongs to,
  // and whether a read was actually issued for it (dead edge slots read as 0).
  logic             lat_vld_q, lat_vld_d;
  logic [3:0]       lat_idx_q, lat_idx_d;
  logic             lat_rd_q, lat_rd_d;

  logic [ADDR_W-1:0] nb_addr;
  logic              nb_in_grid;
  logic [IDX_W-1:0]  cell_addr;
  logic              last_cell;

  gol_nbr_addr #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_nbr_addr (
    .x       (x_q),
    .y       (y_q),
    .k       (k_q),
    .bank    (bank_q),
    .addr    (nb_addr),
    .in_grid (nb_in_grid)
  );

  assign cell_addr = IDX_W'(int'(y_q) * WIDTH + int'(x_q));
  assign last_cell = (x_q == X_W'(WIDTH - 1)) && (y_q == Y_W'(HEIGHT - 1));

  always_comb begin
    rd_en   = (state_q == ST_FETCH) && nb_in_grid;
    rd_addr = rd_en ? nb_addr : '0;
    wr_en   = (state_q == ST_WRITE);
    wr_data = wr_en & life_rule(status_q);
    wr_addr = wr_en ? {~bank_q, cell_addr} : '0;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_bank   = bank_q;
  assign live_count = live_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bank_d   = bank_q;
    acc_d    = acc_q;
    live_d   = live_q;
    status_d = status_q;

    lat_vld_d = (state_q == ST_FETCH);
    lat_idx_d = k_q;
    lat_rd_d  = rd_en;

    if (lat_vld_q) begin
      for (int i = 0; i < 9; i++) begin
        if (lat_idx_q == 4'(i)) begin
          status_d[i] = lat_rd_q & rd_data;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        // busy stays high across a back-to-back start, else drops with done
        busy_d = start;
        if (start) begin
          state_d = ST_FETCH;
          x_d     = '0;
          y_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      ST_FETCH: begin
        if (k_q == NB_SE) begin
          state_d = ST_CAPTURE;
          k_d     = '0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        acc_d = acc_q + CNT_W'(wr_data);
        if (last_cell) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_FETCH;
          k_d     = '0;
          if (x_q == X_W'(WIDTH - 1)) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        bank_d  = ~bank_q;
        live_d  = acc_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      k_q       <= '0;
      status_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bank_q    <= 1'b0;
      acc_q     <= '0;
      live_q    <= '0;
      lat_vld_q <= 1'b0;
      lat_idx_q <= '0;
      lat_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      k_q       <= k_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bank_q    <= bank_d;
      acc_q     <= acc_d;
      live_q    <= live_d;
      lat_vld_q <= lat_vld_d;
      lat_idx_q <= lat_idx_d;
      lat_rd_q  <= lat_rd_d;
    end
  end

endmodule

// File: tb/tb_generation_scheduler.sv
// Bench for generation_scheduler on a 5x5 grid with a behavioural RAM and a
// coordinate-level Game-of-Life reference model. Expected writes and completions
// are queued at start time; a monitor pops and compares as the DUT produces them.
module tb_generation_scheduler;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int N  = W * H;
  localparam int AW = $clog2(N) + 1;
  localparam int IW = AW - 1;
  localparam int CW = $clog2(N + 1);
  localparam int P  = 11 * N + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, cur_bank, rd_en, wr_en, wr_data;
  logic          rd_data = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [CW-1:0] live_count;

  logic mem [2**AW];

  typedef struct {
    longint       cyc;
    int           live;
    logic         bank;
    logic [N-1:0] grid;
  } exp_t;

  exp_t        eq[$];
  logic [AW:0] wq[$];

  int     tests = 0;
  int     fails = 0;
  int     proto_err = 0;
  longint cyc = 0;

  logic         model_bank;
  logic [N-1:0] model_grid;

  generation_scheduler #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .cur_bank   (cur_bank),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .live_count (live_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] get_grid(input logic b);
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = mem[(int'(b) << IW) + i];
    return g;
  endfunction

  function automatic logic [N-1:0] evolve(input logic [N-1:0] g);
    logic [N-1:0] r;
    int n, nx, ny;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (dx == 0 && dy == 0) continue;
            nx = x + dx;
            ny = y + dy;
`ifdef TORUS_WRAP_EN
            nx = (nx + W) % W;
            ny = (ny + H) % H;
`endif
            if (nx >= 0 && nx < W && ny >= 0 && ny < H) n += int'(g[ny * W + nx]);
          end
        end
        r[y * W + x] = g[y * W + x] ? (n == 2 || n == 3) : (n == 3);
      end
    end
    return r;
  endfunction

  task automatic load_grid(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) begin
      mem[(int'(model_bank) << IW) + i] = g[i];
      mem[(int'(~model_bank) << IW) + i] = 1'($urandom_range(0, 1));
    end
    model_grid = g;
  endtask

  function automatic logic [N-1:0] rand_grid();
    logic [N-1:0] g;
    for (int i = 0; i < N; i++) g[i] = ($urandom_range(0, 99) < 40);
    return g;
  endfunction

  // Called at a negedge with the DUT idle; start is accepted at the next posedge.
  task automatic issue(input int ngen);
    longint       s;
    logic [N-1:0] g;
    exp_t         e;
    s = cyc + 1;
    g = model_grid;
    for (int n = 0; n < ngen; n++) begin
      g = evolve(g);
      for (int i = 0; i < N; i++) wq.push_back({~model_bank, IW'(i), g[i]});
      e.cyc  = s + longint'((n + 1) * P - 1);
      e.live = $countones(g);
      e.bank = ~model_bank;
      e.grid = g;
      eq.push_back(e);
      model_bank = ~model_bank;
    end
    model_grid = g;
    start = 1'b1;
    repeat ((ngen - 1) * P + 1) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((eq.size() != 0 || wq.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (eq.size() != 0 || wq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d dones and %0d writes pending, expected 0",
               eq.size(), wq.size());
      eq.delete();
      wq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t        e;
    logic [AW:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) continue;
      if (rd_en && wr_en) proto_err++;
      if (rd_en && rd_addr[AW-1] != cur_bank) proto_err++;
      if (wr_en) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_write: got addr 0x%0h data %0d, expected no write",
                   wr_addr, wr_data);
        end else begin
          w = wq.pop_front();
          check("write_addr_data", {wr_addr, wr_data}, w);
        end
      end
      if (done) begin
        if (eq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = eq.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("live_count", live_count, e.live);
          check("cur_bank", cur_bank, e.bank);
          check("grid", get_grid(cur_bank), e.grid);
          check("busy_at_done", busy, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] g;
    model_bank = 1'b0;
    model_grid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cur_bank", cur_bank, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_live_count", live_count, 0);

    // Vertical blinker at x=2, y=1..3
    g = '0;
    g[7] = 1'b1; g[12] = 1'b1; g[17] = 1'b1;
    load_grid(g);
    issue(1);
    drain(P + 50);
    g = '0;
    g[11] = 1'b1; g[12] = 1'b1; g[13] = 1'b1;
    check("blinker_grid", get_grid(cur_bank), g);
    check("blinker_live", live_count, 3);
    check("blinker_bank", cur_bank, 1);

    // 2x2 block at the corner is stable in both edge modes
    g = '0;
    g[0] = 1'b1; g[1] = 1'b1; g[5] = 1'b1; g[6] = 1'b1;
    load_grid(g);
    issue(1);
    drain(P + 50);
    check("block_grid", get_grid(cur_bank), g);
    check("block_live", live_count, 4);

    // Three corners: edge handling decides everything
    g = '0;
    g[0] = 1'b1; g[4] = 1'b1; g[20] = 1'b1;
    load_grid(g);
    issue(1);
    drain(P + 50);
`ifdef TORUS_WRAP_EN
    g[24] = 1'b1;
    check("corner_grid", get_grid(cur_bank), g);
    check("corner_live", live_count, 4);
`else
    check("corner_grid", get_grid(cur_bank), 0);
    check("corner_live", live_count, 0);
`endif

    // start pulsed mid-generation must be ignored
    load_grid(rand_grid());
    issue(1);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(P + 50);
    repeat (P + 10) @(negedge clk);

    // start held high: two back-to-back generations
    load_grid(rand_grid());
    issue(2);
    drain(2 * P + 50);

    // random generations, some chained on the previous result
    for (int it = 0; it < 4; it++) begin
      if (it % 2 == 0) load_grid(rand_grid());
      issue(1);
      drain(P + 50);
    end

    // reset in the middle of a fetch, then a clean generation
    load_grid(rand_grid());
    issue(1);
    repeat (35) @(negedge clk);
    rst_n = 1'b0;
    eq.delete();
    wq.delete();
    model_bank = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_cur_bank", cur_bank, 0);
    check("midrst_rd_en", rd_en, 0);
    check("midrst_wr_en", wr_en, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("postrst_busy", busy, 0);
    check("postrst_done", done, 0);
    load_grid(rand_grid());
    issue(1);
    drain(P + 50);

    check("rd_wr_protocol_errs", proto_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
